// File: rtl/reg_wr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : reg_wr_decoder
// Description : Registered one-hot register-write decoder with a ready/valid
//               handshake on both sides and a pending-write scoreboard.
//               An accepted write address is decoded to a one-hot write-enable
//               word that appears one cycle later. The word is held while
//               downstream stalls. In parallel, a per-register pend bit is
//               set on every accepted write and cleared by the commit mask
//               clr.
//
// Ports       :
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous active-high reset
//   enable     in   1        global enable; gates acceptance only
//   in_valid   in   1        write request presented
//   in_ready   out  1        request can be accepted this cycle
//   addr       in   ADDR_W   destination register index
//   out_valid  out  1        registered one-hot word is valid
//   out_ready  in   1        downstream takes the word this cycle
//   out        out  NUM_OUT  registered one-hot write-enable
//   pend       out  NUM_OUT  pending-write scoreboard, one bit per register
//   clr        in   NUM_OUT  commit mask clearing pend bits
//
// Configuration macro:
//   XZR_MASK_EN  when defined, the all-ones address (the zero register) is
//                still accepted and produces out_valid, but it drives an
//                all-zero word and sets no pend bit.
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wr_decoder #(
    parameter int ADDR_W  = 5,
    // Must always equal 2**ADDR_W; it is exposed only so that port widths
    // can be named by the instantiating level.
    parameter int NUM_OUT = 2**ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out,
    output logic [NUM_OUT-1:0] pend,
    input  logic [NUM_OUT-1:0] clr
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               r_out_valid;
    logic [NUM_OUT-1:0] r_out;
    logic [NUM_OUT-1:0] r_pend;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_drain;
    logic               w_is_xzr;
    logic [NUM_OUT-1:0] w_onehot;

    // The slot is free when it is empty or is being emptied in this same
    // cycle. That gives full throughput without a bubble. enable only
    // blocks new acceptance, so a held word still drains while disabled.
    assign in_ready = enable & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // ------------------------------------------------------------------
    // Zero-register masking
    // ------------------------------------------------------------------
`ifdef XZR_MASK_EN
    assign w_is_xzr = &addr;
`else
    assign w_is_xzr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // One-hot decode. Every address value is in range, because the
    // output width is exactly 2**ADDR_W.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_decode
        assign w_onehot[i] = (addr == ADDR_W'(i)) & ~w_is_xzr;
    end

    // ------------------------------------------------------------------
    // Output register. An accept has priority over a drain, so that a
    // simultaneous drain-and-accept replaces the word in place.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_onehot;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard. The clear is applied first and the set is
    // OR-ed in afterwards. As a result, a same-cycle set wins over a
    // same-cycle clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~clr) | (w_accept ? w_onehot : '0);
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign pend      = r_pend;

endmodule
`default_nettype wire
